// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, FSM state type and read-tag type for the
// audio BRAM port-B arbiter.
package audio_pkg;

  localparam int BRAM_AW  = 32;
  localparam int BRAM_DW  = 32;
  localparam int BRAM_WEW = BRAM_DW / 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // One in-flight read return: vld = a read is coming back, owner = 0 for r0, 1 for r1.
  typedef struct packed {
    logic vld;
    logic owner;
  } rd_tag_t;

  // BRAM port B is word addressed in bytes; the two LSBs must always be zero.
  function automatic logic [BRAM_AW-1:0] word_align(input logic [BRAM_AW-1:0] byte_addr);
    return byte_addr & {{(BRAM_AW-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/arb_rd_tag_pipe.sv
// arb_rd_tag_pipe: RD_LAT-deep shift register of read tags. The tag pushed
// on a granted beat appears on tag_o exactly RD_LAT cycles later, in step
// with the BRAM read data.
module arb_rd_tag_pipe
  import audio_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);

  rd_tag_t pipe_q [RD_LAT];

  // Advance tags one stage per cycle; reset drops every read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[RD_LAT-1];

endmodule

// File: rtl/audio_bram_arbiter.sv
// audio_bram_arbiter: shares BRAM port B between r0 (I2S playback reader,
// priority, read-only) and r1 (synth buffer reader/writer, bounded bursts).
// Grants are combinational so a granted beat reaches the BRAM in the same
// cycle; owner switches cost no bubble.
// Optional feature: define ARB_STARVE_GUARD_EN to give r1 a forced beat
// after STARVE_MAX cycles of waiting.
module audio_bram_arbiter
  import audio_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int BURST_MAX  = 8
`ifdef ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 64
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                r0_req,
  input  logic [BRAM_AW-1:0]  r0_addr,
  output logic [BRAM_DW-1:0]  r0_rdata,
  output logic                r0_gnt,
  output logic                r0_rvalid,
  input  logic                r1_req,
  input  logic [BRAM_WEW-1:0] r1_we,
  input  logic [BRAM_AW-1:0]  r1_addr,
  input  logic [BRAM_DW-1:0]  r1_wdata,
  output logic                r1_gnt,
  output logic                r1_rvalid,
  output logic [BRAM_DW-1:0]  r1_rdata,
  output logic [BRAM_AW-1:0]  BRAM_addr,
  output logic [BRAM_DW-1:0]  BRAM_din,
  output logic [BRAM_WEW-1:0] BRAM_we,
  output logic                BRAM_en,
  output logic                BRAM_clk,
  output logic                BRAM_rst,
  input  logic [BRAM_DW-1:0]  BRAM_dout
);

  localparam int BCW = $clog2(BURST_MAX + 1);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(BURST_MAX);

  arb_state_t     state_q, state_d;
  logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
  logic           gnt0, gnt1;
  logic           force_r1;    // r1 owns this cycle after starving
  logic           starve_hit;  // r1 has waited long enough; force it next cycle
  rd_tag_t        tag_push, tag_ret;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SCW = $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

  logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
  logic           force_q, force_d;

  // Starvation counter and the one-beat force flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      force_q      <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      force_q      <= force_d;
    end
  end

  assign starve_hit = r1_req && (starve_cnt_q == STARVE_LIM);

  // Count cycles r1 waits (saturating); any r1 grant clears it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    force_d      = 1'b0;
    if (gnt1) begin
      starve_cnt_d = '0;
    end else if (r1_req && !rst) begin
      if (starve_cnt_q != STARVE_LIM) starve_cnt_d = starve_cnt_q + 1'b1;
      force_d = starve_hit;
    end
  end

  assign force_r1 = force_q;
`else
  assign starve_hit = 1'b0;
  assign force_r1   = 1'b0;
`endif

  // FSM state and burst counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Grant decision and next state; the owner of the next cycle is whoever was served now.
  always_comb begin
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;

    if (!rst) begin
      if (force_r1 && r1_req) begin
        gnt1 = 1'b1;
      end else begin
        case (state_q)
          ARB_OWN1: begin
            if (r1_req && (burst_cnt_q != BURST_LIM)) gnt1 = 1'b1;
            else if (r0_req)                           gnt0 = 1'b1;
          end
          default: begin
            // IDLE and OWN0 share the same priority: r0 first.
            if (r0_req)      gnt0 = 1'b1;
            else if (r1_req) gnt1 = 1'b1;
          end
        endcase
      end
    end

    if (gnt0)                     state_d = ARB_OWN0;
    else if (gnt1 && force_r1)    state_d = r0_req ? ARB_OWN0 : ARB_OWN1;
    else if (gnt1)                state_d = ARB_OWN1;
    else                          state_d = ARB_IDLE;

    if (starve_hit && !gnt1) state_d = ARB_OWN1;

    // Burst length only accumulates while staying in OWN1 against a waiting r0.
    if ((state_q != ARB_OWN1) || (state_d != ARB_OWN1) || force_r1) begin
      burst_cnt_d = '0;
    end else if (gnt1 && r0_req) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  // Drive the BRAM bus from the granted requester; quiet bus otherwise.
  always_comb begin
    BRAM_en   = gnt0 | gnt1;
    BRAM_addr = '0;
    BRAM_we   = '0;
    BRAM_din  = '0;
    if (gnt0) begin
      BRAM_addr = word_align(r0_addr);
    end else if (gnt1) begin
      BRAM_addr = word_align(r1_addr);
      BRAM_we   = r1_we;
      BRAM_din  = r1_wdata;
    end
  end

  assign tag_push.vld   = gnt0 | (gnt1 && (r1_we == '0));
  assign tag_push.owner = gnt1;

  arb_rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .tag_i (tag_push),
    .tag_o (tag_ret)
  );

  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;
  assign r0_rvalid = tag_ret.vld && !tag_ret.owner && !rst;
  assign r1_rvalid = tag_ret.vld &&  tag_ret.owner && !rst;
  assign r0_rdata  = BRAM_dout;
  assign r1_rdata  = BRAM_dout;
  assign BRAM_clk  = clk;
  assign BRAM_rst  = rst;

endmodule

// File: tb/tb_audio_bram_arbiter.sv
// tb_audio_bram_arbiter: self-checking bench with a behavioural BRAM
// (2-cycle read latency) and a scoreboard of expected read returns.
`timescale 1ns/1ps
module tb_audio_bram_arbiter;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_req;
  logic [31:0] r0_addr;
  logic [31:0] r0_rdata;
  logic        r0_gnt, r0_rvalid;
  logic        r1_req;
  logic [3:0]  r1_we;
  logic [31:0] r1_addr, r1_wdata;
  logic        r1_gnt, r1_rvalid;
  logic [31:0] r1_rdata;
  logic [31:0] BRAM_addr, BRAM_din, BRAM_dout;
  logic [3:0]  BRAM_we;
  logic        BRAM_en, BRAM_clk, BRAM_rst;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rv_cnt0 = 0;
  int rv_cnt1 = 0;

  logic [31:0] mem     [256];   // BRAM contents as written through the DUT
  logic [31:0] exp_mem [256];   // reference contents maintained by the bench
  logic [31:0] rd_stage;

  typedef struct {
    logic        owner;
    logic [31:0] data;
    int          due;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  audio_bram_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_addr   (r0_addr),
    .r0_rdata  (r0_rdata),
    .r0_gnt    (r0_gnt),
    .r0_rvalid (r0_rvalid),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_gnt    (r1_gnt),
    .r1_rvalid (r1_rvalid),
    .r1_rdata  (r1_rdata),
    .BRAM_addr (BRAM_addr),
    .BRAM_din  (BRAM_din),
    .BRAM_we   (BRAM_we),
    .BRAM_en   (BRAM_en),
    .BRAM_clk  (BRAM_clk),
    .BRAM_rst  (BRAM_rst),
    .BRAM_dout (BRAM_dout)
  );

  // Behavioural BRAM port B: byte writes, read data valid two cycles after en.
  always @(posedge clk) begin
    if (BRAM_en) begin
      for (int b = 0; b < 4; b++)
        if (BRAM_we[b]) mem[BRAM_addr[9:2]][8*b +: 8] <= BRAM_din[8*b +: 8];
      rd_stage <= mem[BRAM_addr[9:2]];
    end
    BRAM_dout <= rd_stage;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop/compare returned reads, then record this cycle's granted beats.
  always @(negedge clk) begin
    sb_t e;
    if (rst) begin
      sb.delete();
    end else begin
      if (r0_rvalid || r1_rvalid) begin
        if (r0_rvalid) rv_cnt0++;
        if (r1_rvalid) rv_cnt1++;
        total++;
        if (r0_rvalid && r1_rvalid) begin
          bad++;
          $display("FAIL rvalid_both: r0_rvalid=1 r1_rvalid=1 cycle=%0d, required at most one", cyc);
        end else if (sb.size() == 0) begin
          bad++;
          $display("FAIL rvalid_unexpected: r0_rvalid=%0b r1_rvalid=%0b cycle=%0d, required none",
                   r0_rvalid, r1_rvalid, cyc);
        end else begin
          e = sb.pop_front();
          if (r1_rvalid !== e.owner || (r1_rvalid ? r1_rdata : r0_rdata) !== e.data || cyc != e.due) begin
            bad++;
            $display("FAIL rd_return: owner=%0b data=%h cycle=%0d, required owner=%0b data=%h cycle=%0d",
                     r1_rvalid, (r1_rvalid ? r1_rdata : r0_rdata), cyc, e.owner, e.data, e.due);
          end else begin
            $display("rd return owner=r%0b data=%h cycle=%0d", e.owner, e.data, cyc);
          end
        end
      end
      if (r0_gnt && r1_gnt) begin
        total++;
        bad++;
        $display("FAIL gnt_exclusive: r0_gnt=1 r1_gnt=1 cycle=%0d, required one grant", cyc);
      end
      if (r0_gnt) sb.push_back('{owner: 1'b0, data: exp_mem[r0_addr[9:2]], due: cyc + RD_LAT});
      if (r1_gnt) begin
        if (r1_we == 4'b0) begin
          sb.push_back('{owner: 1'b1, data: exp_mem[r1_addr[9:2]], due: cyc + RD_LAT});
        end else begin
          for (int b = 0; b < 4; b++)
            if (r1_we[b]) exp_mem[r1_addr[9:2]][8*b +: 8] = r1_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic idle_cycles(input int n);
    @(posedge clk); #1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    r1_we  = 4'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; r0_req = 1'b1; r1_req = 1'b1; r1_we = 4'hF;
    r0_addr = 32'h44; r1_addr = 32'h48; r1_wdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, BRAM_en} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl: gnt0/gnt1/rv0/rv1/en=%b, required 00000",
               {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, BRAM_en});
    end
    total++;
    if (BRAM_we !== 4'b0 || BRAM_addr !== 32'b0 || BRAM_din !== 32'b0) begin
      bad++;
      $display("FAIL reset_bus: we=%h addr=%h din=%h, required all zero", BRAM_we, BRAM_addr, BRAM_din);
    end
    total++;
    if (BRAM_rst !== 1'b1 || BRAM_clk !== clk) begin
      bad++;
      $display("FAIL reset_passthru: BRAM_rst=%b BRAM_clk=%b, required 1 and %b", BRAM_rst, BRAM_clk, clk);
    end
    @(posedge clk); #1;
    rst = 1'b0; r0_req = 1'b0; r1_req = 1'b0; r1_we = 4'b0;
    @(negedge clk);
    total++;
    if ({r0_gnt, r1_gnt, BRAM_en} !== 3'b0) begin
      bad++;
      $display("FAIL idle_after_reset: gnt0/gnt1/en=%b, required 000", {r0_gnt, r1_gnt, BRAM_en});
    end
  endtask

  task automatic test_r0_stream;
    int start_cnt;
    start_cnt = rv_cnt0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      r0_req = 1'b1; r0_addr = 32'(i * 4);
      @(negedge clk);
      total++;
      if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
        bad++;
        $display("FAIL r0_stream_gnt: beat %0d gnt0=%b gnt1=%b, required 1 0", i, r0_gnt, r1_gnt);
      end
      total++;
      if (BRAM_en !== 1'b1 || BRAM_we !== 4'b0 || BRAM_addr !== 32'(i * 4)) begin
        bad++;
        $display("FAIL r0_stream_bus: en=%b we=%h addr=%h, required 1 0 %h", BRAM_en, BRAM_we, BRAM_addr, 32'(i * 4));
      end
    end
    idle_cycles(5);
    total++;
    if (rv_cnt0 - start_cnt != 3) begin
      bad++;
      $display("FAIL r0_stream_returns: got %0d r0 returns, required 3", rv_cnt0 - start_cnt);
    end
  endtask

  task automatic test_simultaneous;
    @(posedge clk); #1;
    r0_req = 1'b1; r0_addr = 32'h33;
    r1_req = 1'b1; r1_we = 4'b0; r1_addr = 32'h40;
    @(negedge clk);
    total++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
      bad++;
      $display("FAIL simul_priority: gnt0=%b gnt1=%b, required 1 0", r0_gnt, r1_gnt);
    end
    total++;
    if (BRAM_addr !== 32'h30) begin
      bad++;
      $display("FAIL addr_align: BRAM_addr=%h, required 00000030", BRAM_addr);
    end
    @(posedge clk); #1;
    r0_req = 1'b0;
    @(negedge clk);
    total++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
      bad++;
      $display("FAIL switch_no_bubble: gnt0=%b gnt1=%b, required 0 1", r0_gnt, r1_gnt);
    end
    idle_cycles(4);
  endtask

  task automatic test_burst;
    int  cnt, bubbles;
    logic got0, g0, g1;
    @(posedge clk); #1;
    r1_req = 1'b1; r1_we = 4'b0; r1_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0) begin
        bad++;
        $display("FAIL burst_solo: beat %0d gnt0=%b gnt1=%b, required 0 1", i, r0_gnt, r1_gnt);
      end
      @(posedge clk); #1;
      r1_addr += 32'd4;
      if (i == 1) begin
        r0_req = 1'b1; r0_addr = 32'h100;
      end
    end
    cnt = 0; bubbles = 0; got0 = 1'b0;
    for (int c = 0; c < 30 && !got0; c++) begin
      @(negedge clk);
      g0 = r0_gnt; g1 = r1_gnt;
      if (g1) cnt++;
      if (g0) got0 = 1'b1;
      if (!g0 && !g1) bubbles++;
      @(posedge clk); #1;
      if (g1) r1_addr += 32'd4;
      if (g0) r0_addr += 32'd4;
    end
    total++;
    if (!got0 || cnt != 8) begin
      bad++;
      $display("FAIL burst_len: r1 beats=%0d r0_granted=%b, required 8 and 1", cnt, got0);
    end
    total++;
    if (bubbles != 0) begin
      bad++;
      $display("FAIL burst_bubble: idle cycles=%0d, required 0", bubbles);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
        bad++;
        $display("FAIL burst_r0_holds: cycle %0d gnt0=%b gnt1=%b, required 1 0", c, r0_gnt, r1_gnt);
      end
      @(posedge clk); #1;
      r0_addr += 32'd4;
    end
    idle_cycles(5);
  endtask

  task automatic test_write_read;
    logic        got, r0_seen;
    logic [31:0] data;
    @(posedge clk); #1;
    r1_req = 1'b1; r1_we = 4'b0011; r1_addr = 32'h10; r1_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total++;
    if (r1_gnt !== 1'b1 || BRAM_we !== 4'b0011 || BRAM_din !== 32'hDEAD_BEEF || BRAM_addr !== 32'h10) begin
      bad++;
      $display("FAIL wr_bus: gnt1=%b we=%h din=%h addr=%h, required 1 3 deadbeef 00000010",
               r1_gnt, BRAM_we, BRAM_din, BRAM_addr);
    end
    @(posedge clk); #1;
    r1_we = 4'b0;
    @(negedge clk);
    total++;
    if (r1_gnt !== 1'b1 || BRAM_we !== 4'b0) begin
      bad++;
      $display("FAIL rd_bus: gnt1=%b we=%h, required 1 0", r1_gnt, BRAM_we);
    end
    @(posedge clk); #1;
    r1_req = 1'b0;
    got = 1'b0; r0_seen = 1'b0; data = '0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      if (r0_rvalid) r0_seen = 1'b1;
      if (r1_rvalid) begin
        got  = 1'b1;
        data = r1_rdata;
      end
    end
    total++;
    if (!got || data !== 32'hA500_BEEF) begin
      bad++;
      $display("FAIL wr_rd_data: got=%b r1_rdata=%h, required 1 a500beef", got, data);
    end
    total++;
    if (r0_seen) begin
      bad++;
      $display("FAIL wr_rd_steer: r0_rvalid=1, required 0");
    end
    idle_cycles(3);
  endtask

  task automatic test_reset_midflight;
    @(posedge clk); #1;
    r0_req = 1'b1; r0_addr = 32'h20;
    @(negedge clk);
    total++;
    if (r0_gnt !== 1'b1) begin
      bad++;
      $display("FAIL midrst_gnt: gnt0=%b, required 1", r0_gnt);
    end
    @(posedge clk); #1;
    r0_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, BRAM_en} !== 5'b0 ||
        BRAM_we !== 4'b0 || BRAM_addr !== 32'b0 || BRAM_din !== 32'b0) begin
      bad++;
      $display("FAIL midrst_outputs: ctrl=%b we=%h addr=%h din=%h, required all zero",
               {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, BRAM_en}, BRAM_we, BRAM_addr, BRAM_din);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_flush: cycle %0d rv0=%b rv1=%b, required 0 0", c, r0_rvalid, r1_rvalid);
      end
    end
  endtask

  task automatic test_starve;
    int   waited;
    logic got;
    @(posedge clk); #1;
    r0_req = 1'b1; r0_addr = 32'h0;
    r1_req = 1'b1; r1_we = 4'hF; r1_addr = 32'hF0; r1_wdata = 32'h1234_5678;
    waited = 0; got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (r1_gnt) got = 1'b1;
      else waited++;
      @(posedge clk); #1;
      r0_addr = (r0_addr + 32'd4) & 32'h3FC;
    end
`ifdef ARB_STARVE_GUARD_EN
    total++;
    if (!got || waited != 65) begin
      bad++;
      $display("FAIL starve_grant: granted=%b waited=%0d, required 1 and 65", got, waited);
    end
    @(negedge clk);
    total++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin
      bad++;
      $display("FAIL starve_one_beat: gnt0=%b gnt1=%b, required 1 0", r0_gnt, r1_gnt);
    end
`else
    total++;
    if (got) begin
      bad++;
      $display("FAIL starve_none: r1 granted after %0d cycles, required no grant", waited);
    end
`endif
    idle_cycles(5);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | 32'(i * 4);
      exp_mem[i] = 32'hA500_0000 | 32'(i * 4);
    end
    rd_stage = '0;
    rst = 1'b1; r0_req = 1'b0; r1_req = 1'b0; r1_we = 4'b0;
    r0_addr = '0; r1_addr = '0; r1_wdata = '0;

    test_reset();
    test_r0_stream();
    test_simultaneous();
    test_burst();
    test_write_read();
    test_reset_midflight();
    test_starve();

    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: %0d reads never returned, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
